pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the MIPS fetch stage and successor to the free-running word counter. It produces the fetch address each cycle, supporting:
- byte-address stepping, fetch back-pressure and stalls;
- branch/jump redirects, exceptions with EPC capture, and exception return;
- a small circular return-address stack (RAS) for call/return.

The block sits between the control unit, hazard unit and instruction memory.

---
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between control/hazard units, the PC sequencer and instruction memory.
// Latency: none, pure wiring.
// Backpressure: fetch_ready from instruction memory holds the presented address.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             fetch_ready;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic             exception;
    logic             exc_return;
    logic [WIDTH-1:0] program_counter;
    logic             pc_valid;
    logic [WIDTH-1:0] epc;
    logic             ras_empty;
    logic             ras_full;

    // Control side: issues redirects, traps and back-pressure, observes the fetch address.
    modport master (
        output stall, fetch_ready, redirect_valid, redirect_target,
               call, ret, exception, exc_return,
        input  program_counter, pc_valid, epc, ras_empty, ras_full
    );

    // Sequencer side.
    modport slave (
        input  stall, fetch_ready, redirect_valid, redirect_target,
               call, ret, exception, exc_return,
        output program_counter, pc_valid, epc, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential stepping, redirects, traps/eret and a circular RAS.
// Latency: every request sampled at an edge is visible on the registered outputs after that edge.
// Backpressure: stall or fetch_ready=0 holds the PC; redirects are taken regardless.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    pc_sequencer_if.slave   bus
);
    localparam int               PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    // STEP is a power of two, so STEP-1 is exactly the set of sub-step address bits.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] epc_q;
    logic [WIDTH-1:0] epc_d;
    logic             pc_valid;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic [CNT_W-1:0] cnt_q;
    logic             ras_empty;
    logic             ras_full;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] push_val;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_MAX);
    assign top_inc   = top_q + PTR_W'(1);
    assign top_dec   = top_q - PTR_W'(1);
    // Return address wraps modulo 2^WIDTH like the sequential step.
    assign push_val  = pc_q + STEP_W;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one BOOT cycle, TRAP persists while exception is held.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = bus.exception ? TRAP : RUN;
            TRAP:    state_d = bus.exception ? TRAP : RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs: only RUN presents a real fetch request.
    always_comb begin
        pc_valid = 1'b0;
        unique case (state_q)
            RUN:     pc_valid = 1'b1;
            default: pc_valid = 1'b0;
        endcase
    end

    // Next-PC selection by priority, plus the RAS actions the winning event implies.
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        do_push = 1'b0;
        do_pop  = 1'b0;
        unique case (state_q)
            BOOT: begin
                pc_d = pc_q;
            end
            TRAP: begin
                // epc is deliberately not recaptured while the trap is held.
                pc_d = EXC_VECTOR;
            end
            RUN: begin
                if (bus.exception) begin
                    epc_d = pc_q;
                    pc_d  = EXC_VECTOR;
                end else if (bus.exc_return) begin
                    pc_d = align(epc_q);
                end else if (bus.redirect_valid) begin
                    do_pop  = bus.ret && !ras_empty;
                    do_push = bus.call;
                    pc_d    = do_pop ? align(ras_mem[top_q]) : align(bus.redirect_target);
                end else if (!bus.stall && bus.fetch_ready) begin
                    pc_d = pc_q + STEP_W;
                end
            end
            default: begin
                pc_d = RESET_VECTOR;
            end
        endcase
    end

    // PC and EPC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

    // Return-address stack: pop-then-push replaces the top in place, push on full drops the oldest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            top_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (do_pop && do_push) begin
            ras_mem[top_q] <= push_val;
        end else if (do_pop) begin
            top_q <= top_dec;
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (do_push) begin
            top_q            <= top_inc;
            ras_mem[top_inc] <= push_val;
            if (!ras_full) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.program_counter = pc_q;
    assign bus.pc_valid        = pc_valid;
    assign bus.epc             = epc_q;
    assign bus.ras_empty       = ras_empty;
    assign bus.ras_full        = ras_full;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stall, back-pressure, wrap, traps, RAS and async reset.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: fetch_ready is driven low explicitly in one directed segment.
module tb_pc_sequencer;
    logic clk;
    logic reset_n;
    int   n_total;
    int   n_pass;
    int   n_fail;

    pc_sequencer_if #(.WIDTH(32)) bus ();

    pc_sequencer #(
        .WIDTH        (32),
        .STEP         (4),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h8000_0180),
        .RAS_DEPTH    (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.stall           = 1'b0;
        bus.fetch_ready     = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.call            = 1'b0;
        bus.ret             = 1'b0;
        bus.exception       = 1'b0;
        bus.exc_return      = 1'b0;
    endtask

    task automatic redir(input logic [31:0] tgt, input logic c, input logic r);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = tgt;
        bus.call            = c;
        bus.ret             = r;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        idle_in();
        step();
        step();
        chk("rst_pc", bus.program_counter, 32'h0);
        chk("rst_valid", bus.pc_valid, 1'b0);
        chk("rst_epc", bus.epc, 32'h0);
        chk("rst_empty", bus.ras_empty, 1'b1);
        chk("rst_full", bus.ras_full, 1'b0);

        // Boot: one BOOT cycle, then 0x0, 0x4, 0x8.
        reset_n = 1'b1;
        chk("boot_valid", bus.pc_valid, 1'b0);
        step();
        chk("run_valid", bus.pc_valid, 1'b1);
        chk("run_pc0", bus.program_counter, 32'h0);
        step();
        chk("run_pc4", bus.program_counter, 32'h4);
        step();
        chk("run_pc8", bus.program_counter, 32'h8);

        // Stall two cycles at 0x8.
        bus.stall = 1'b1;
        step();
        chk("stall1", bus.program_counter, 32'h8);
        step();
        chk("stall2", bus.program_counter, 32'h8);
        bus.stall = 1'b0;
        step();
        chk("stall_rel", bus.program_counter, 32'hC);

        // Back-pressure: same address re-presented, still valid.
        bus.fetch_ready = 1'b0;
        step();
        step();
        step();
        chk("bp_pc", bus.program_counter, 32'hC);
        chk("bp_valid", bus.pc_valid, 1'b1);
        bus.fetch_ready = 1'b1;

        // Wrap at the top of the address space.
        redir(32'hFFFF_FFFC, 1'b0, 1'b0);
        step();
        chk("redir_top", bus.program_counter, 32'hFFFF_FFFC);
        idle_in();
        step();
        chk("wrap", bus.program_counter, 32'h0);

        // Exception beats redirect and stall.
        redir(32'h40, 1'b0, 1'b0);
        step();
        chk("redir_40", bus.program_counter, 32'h40);
        redir(32'h100, 1'b0, 1'b0);
        bus.exception = 1'b1;
        bus.stall     = 1'b1;
        step();
        idle_in();
        chk("exc_epc", bus.epc, 32'h40);
        chk("exc_bubble", bus.pc_valid, 1'b0);
        chk("exc_trap_pc", bus.program_counter, 32'h8000_0180);
        step();
        chk("exc_vec_pc", bus.program_counter, 32'h8000_0180);
        chk("exc_vec_valid", bus.pc_valid, 1'b1);
        bus.exc_return = 1'b1;
        step();
        idle_in();
        chk("eret_pc", bus.program_counter, 32'h40);

        // Misaligned target is forced to a STEP boundary.
        redir(32'h13, 1'b0, 1'b0);
        step();
        chk("align", bus.program_counter, 32'h10);

        // Call then return.
        redir(32'h200, 1'b1, 1'b0);
        step();
        chk("call_pc", bus.program_counter, 32'h200);
        chk("call_nonempty", bus.ras_empty, 1'b0);
        redir(32'hDEAD, 1'b0, 1'b1);
        step();
        chk("ret_pc", bus.program_counter, 32'h14);
        chk("ret_empty", bus.ras_empty, 1'b1);
        redir(32'h300, 1'b0, 1'b1);
        step();
        chk("ret_empty_pc", bus.program_counter, 32'h300);

        // Overflow: five calls into a four-deep stack.
        redir(32'h0, 1'b0, 1'b0);
        step();
        redir(32'h10, 1'b1, 1'b0);
        step();
        redir(32'h20, 1'b1, 1'b0);
        step();
        redir(32'h30, 1'b1, 1'b0);
        step();
        redir(32'h40, 1'b1, 1'b0);
        step();
        chk("ovf_full4", bus.ras_full, 1'b1);
        redir(32'h500, 1'b1, 1'b0);
        step();
        chk("ovf_pc", bus.program_counter, 32'h500);
        chk("ovf_full5", bus.ras_full, 1'b1);
        redir(32'hBAD0, 1'b0, 1'b1);
        step();
        chk("ovf_ret1", bus.program_counter, 32'h44);
        chk("ovf_notfull", bus.ras_full, 1'b0);
        step();
        chk("ovf_ret2", bus.program_counter, 32'h34);
        step();
        chk("ovf_ret3", bus.program_counter, 32'h24);
        step();
        chk("ovf_ret4", bus.program_counter, 32'h14);
        chk("ovf_empty", bus.ras_empty, 1'b1);

        // call+ret together replaces the top entry.
        redir(32'h600, 1'b1, 1'b0);
        step();
        redir(32'h700, 1'b1, 1'b1);
        step();
        chk("cr_pc", bus.program_counter, 32'h18);
        chk("cr_nonempty", bus.ras_empty, 1'b0);
        redir(32'h0, 1'b0, 1'b1);
        step();
        chk("cr_ret_pc", bus.program_counter, 32'h604);
        chk("cr_empty", bus.ras_empty, 1'b1);

        // Two entries held plus a captured epc, then asynchronous reset.
        redir(32'h800, 1'b1, 1'b0);
        step();
        redir(32'h900, 1'b1, 1'b0);
        step();
        idle_in();
        bus.exception = 1'b1;
        step();
        idle_in();
        step();
        chk("pre_rst_epc", bus.epc, 32'h900);
        chk("pre_rst_nonempty", bus.ras_empty, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pc", bus.program_counter, 32'h0);
        chk("arst_valid", bus.pc_valid, 1'b0);
        chk("arst_empty", bus.ras_empty, 1'b1);
        chk("arst_epc", bus.epc, 32'h0);

        // After re-boot the stack is really empty: ret falls back to the target.
        step();
        reset_n = 1'b1;
        step();
        redir(32'h20, 1'b0, 1'b1);
        step();
        idle_in();
        chk("post_rst_ret", bus.program_counter, 32'h20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
